// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit front end for a single-port, word-wide data
// memory. The unit takes one byte, halfword or word access from the pipeline
// and returns exactly one completion pulse for it. Sub-word stores are done
// as read-merge-write. Misaligned or out-of-range accesses complete with a
// fault flag and never touch memory.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   req_valid          request present
//   req_write          1 = store, 0 = load
//   req_size           00 byte, 01 halfword, 10 word, 11 illegal (misalign)
//   req_signed         loads: 1 = sign-extend, 0 = zero-extend
//   req_addr           byte address
//   req_wdata          store data, right-justified
//   busy               stall; high in every state except IDLE
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data (0 for stores, faults, and outside resp)
//   misalign, oor      fault flags, valid with resp_valid
//   mem_address        word-aligned address to memory (0 when no access)
//   mem_writeData      write word
//   mem_memWrite       write enable (memory writes on the rising edge)
//   mem_memRead        read enable (mem_readData is combinational)
//   mem_readData       read word from memory
//   fsm_state          current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// busy=0. The request fields are latched on that edge, so the pipeline may
// change them afterwards. While busy=1, req_valid is ignored. The single
// response is the cycle where resp_valid=1.
module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        oor,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ST_RD = 3'd2,
    S_ST_WR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic        oor_q;

  // Fault decode on the incoming (not yet latched) request.
  logic [2:0]  size_bytes;
  logic [32:0] end_addr;
  logic        mis_in;
  logic        oor_in;

  always_comb begin
    size_bytes = 3'd0;
    mis_in     = 1'b0;
    case (req_size)
      2'd0: size_bytes = 3'd1;
      2'd1: begin
        size_bytes = 3'd2;
        mis_in     = req_addr[0];
      end
      2'd2: begin
        size_bytes = 3'd4;
        mis_in     = (req_addr[1:0] != 2'b00);
      end
      default: mis_in = 1'b1;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    end_addr = {1'b0, req_addr} + {30'd0, size_bytes};
    oor_in   = (end_addr > 33'(MEM_BYTES));
  end

  // Lane extraction for loads and lane merge for sub-word stores, both
  // driven from the latched request.
  logic [4:0]  lane_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    lane_sh = {addr_q[1:0], 3'b000};
    ld_byte = mem_readData[lane_sh +: 8];
    ld_half = addr_q[1] ? mem_readData[31:16] : mem_readData[15:0];
    case (size_q)
      2'd0:    load_val = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'd1:    load_val = {{16{signed_q & ld_half[15]}}, ld_half};
      default: load_val = mem_readData;
    endcase

    merged = mem_readData;
    case (size_q)
      2'd0: merged[lane_sh +: 8] = wdata_q[7:0];
      2'd1: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = mem_readData;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
      mis_q    <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (mis_in || oor_in) begin
              // Misalign wins, so at most one flag is raised.
              mis_q <= mis_in;
              oor_q <= ~mis_in & oor_in;
              state <= S_RESP;
            end else if (!req_write) begin
              state <= S_LOAD;
            end else if (req_size == 2'd2) begin
              state <= S_ST_WR;
            end else begin
              state <= S_ST_RD;
            end
          end
        end
        S_LOAD: begin
          rdata_q <= load_val;
          state   <= S_RESP;
        end
        S_ST_RD: begin
          merge_q <= merged;
          state   <= S_ST_WR;
        end
        S_ST_WR: state <= S_RESP;
        S_RESP: begin
          // Clearing here keeps the response fields at 0 outside RESP.
          rdata_q <= 32'd0;
          mis_q   <= 1'b0;
          oor_q   <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory enables decode from state alone, so an asynchronous reset drops
  // them immediately, including a write in progress.
  always_comb begin
    busy          = (state != S_IDLE);
    resp_valid    = (state == S_RESP);
    resp_rdata    = rdata_q;
    misalign      = mis_q;
    oor           = oor_q;
    mem_memRead   = (state == S_LOAD) || (state == S_ST_RD);
    mem_memWrite  = (state == S_ST_WR);
    mem_address   = (mem_memRead || mem_memWrite) ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_writeData = 32'd0;
    if (state == S_ST_WR) mem_writeData = (size_q == 2'd2) ? wdata_q : merge_q;
    fsm_state     = state;
  end

  logic unused_ok;
  assign unused_ok = write_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl. It uses a word memory attached to the memory port
// and a byte-array reference model that computes expected load data, fault
// flags, latency and memory traffic directly from the access rules.
module tb_lsu_mem_ctrl;
  localparam int MEM_BYTES = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        busy, resp_valid, misalign, oor, mem_memWrite, mem_memRead;
  logic [31:0] resp_rdata, mem_address, mem_writeData, mem_readData;
  logic [2:0]  fsm_state;

  lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign(misalign), .oor(oor),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData), .fsm_state(fsm_state)
  );

  // ---------------- attached memory ----------------
  logic [31:0] mem [0:127];
  logic        mem_init = 1'b0;
  assign mem_readData = mem[mem_address[8:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
    end else if (mem_memWrite) begin
      mem[mem_address[8:2]] <= mem_writeData;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];          // {misalign, oor, rdata}
  logic [7:0]  ref_bytes [0:MEM_BYTES-1];
  logic [31:0] last_rdata;
  logic [1:0]  last_flags;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: applies one access to the byte array, queues the
  // expected response and reports expected latency and memory traffic.
  task automatic model_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output int rd, output int wr);
    int nb;
    logic mis, range_err;
    longint v;
    logic [31:0] rdat;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    mis = (nb == 0) ? 1'b1 : ((int'(a[1:0]) % nb) != 0);
    range_err = !mis && ((longint'({32'd0, a}) + longint'(nb)) > longint'(MEM_BYTES));
    rdat = 32'd0;
    if (mis || range_err) begin
      lat = 1; rd = 0; wr = 0;
    end else if (!w) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (longint'(ref_bytes[int'(a) + i]) << (8 * i));
      if (sg && v[8 * nb - 1]) v = v - (longint'(1) << (8 * nb));
      rdat = v[31:0];
      lat = 2; rd = 1; wr = 0;
    end else begin
      for (int i = 0; i < nb; i++) ref_bytes[int'(a) + i] = wd[8 * i +: 8];
      lat = (nb == 4) ? 2 : 3; rd = (nb == 4) ? 0 : 1; wr = 1;
    end
    exp_q.push_back({mis, range_err, rdat});
  endtask

  // Monitor: response contents, quiet response fields, enable exclusivity.
  always @(negedge clk) begin
    logic [33:0] e;
    check("en_excl", 32'(mem_memRead & mem_memWrite), 32'd0);
    if (mem_memRead || mem_memWrite) check("addr_align", 32'(mem_address[1:0]), 32'd0);
    else                             check("addr_idle", mem_address, 32'd0);
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e[31:0]);
        check("resp_flags", 32'({misalign, oor}), 32'(e[33:32]));
      end
    end else begin
      check("quiet_resp", 32'({misalign, oor}), 32'd0);
      check("quiet_rdata", resp_rdata, 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int lat, rd, wr, cyc, rd_cnt, wr_cnt;
    model_req(w, sz, sg, a, wd, lat, rd, wr);
    cyc = 0;
    while (busy && cyc < 20) begin @(negedge clk); cyc++; end
    check("idle_wait", 32'(busy), 32'd0);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;   // latched copy must be used
    rd_cnt = 0; wr_cnt = 0; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      rd_cnt += int'(mem_memRead);
      wr_cnt += int'(mem_memWrite);
    end while (!resp_valid && cyc < 10);
    last_rdata = resp_rdata;
    last_flags = {misalign, oor};
    check("latency", 32'(cyc), 32'(lat));
    check("rd_pulses", 32'(rd_cnt), 32'(rd));
    check("wr_pulses", 32'(wr_cnt), 32'(wr));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int k;
    logic [31:0] bb_addr [0:2];
    logic [1:0]  bb_size [0:2];
    logic        bb_sg [0:2];
    int lat, rd, wr;

    for (int i = 0; i < MEM_BYTES; i++) ref_bytes[i] = 8'd0;
    mem_init = 1'b1;
    req_valid = 1'b1;                       // ignored while in reset
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    check("rst_outs", {busy, resp_valid, misalign, oor, mem_memWrite, mem_memRead, fsm_state},
          32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_maddr", mem_address, 32'd0);
    check("rst_wdata", mem_writeData, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then load
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("lw_data", last_rdata, 32'hDEADBEEF);

    // Byte merge
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AB);
    check("sb_mem", mem[4], 32'h11AB3344);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
    check("lb_data", last_rdata, 32'hFFFFFFAB);
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
    check("lbu_data", last_rdata, 32'h000000AB);

    // Halfword
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80017FFF);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    check("lh_data", last_rdata, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    check("lhu_data", last_rdata, 32'h00007FFF);
    do_req(1'b1, 2'd1, 1'b0, 32'h10, 32'hFFFF1234);
    check("sh_mem", mem[4], 32'h80011234);

    // Faults
    do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
    check("lw_mis_flags", 32'(last_flags), 32'd2);
    do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h55555555);
    check("sw_oor_flags", 32'(last_flags), 32'd1);
    do_req(1'b0, 2'd1, 1'b1, 32'h1FF, 32'h0);
    check("lh_mis_flags", 32'(last_flags), 32'd2);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
    check("size3_flags", 32'(last_flags), 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0);   // last in-range word
    check("edge_flags", 32'(last_flags), 32'd0);

    // Reset during the write cycle of a byte store
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'hAB; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stwr_we", 32'(mem_memWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_we_drop", 32'(mem_memWrite), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_keep", mem[4], 32'h11223344);
    check("rst_busy_after", 32'(busy), 32'd0);
    check("rst_no_pending", 32'(exp_q.size()), 32'd0);

    // Back-to-back loads with req_valid held high
    bb_addr[0] = 32'h10; bb_size[0] = 2'd2; bb_sg[0] = 1'b0;
    bb_addr[1] = 32'h13; bb_size[1] = 2'd0; bb_sg[1] = 1'b1;
    bb_addr[2] = 32'h12; bb_size[2] = 2'd1; bb_sg[2] = 1'b0;
    for (int i = 0; i < 3; i++) model_req(1'b0, bb_size[i], bb_sg[i], bb_addr[i], 32'd0, lat, rd, wr);
    k = 0;
    for (int c = 0; c < 40 && (k < 3 || exp_q.size() != 0); c++) begin
      if (!busy) begin
        if (k < 3) begin
          req_write = 1'b0; req_size = bb_size[k]; req_signed = bb_sg[k];
          req_addr = bb_addr[k]; req_valid = 1'b1;
          k++;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_issued", 32'(k), 32'd3);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, MEM_BYTES + 15));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Final memory image against the reference bytes
    @(negedge clk);
    for (int w = 0; w < 128; w++)
      check("mem_image", mem[w], {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
